// File: rtl/tw45_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tw45_addr_seq                                                   |
// | Function : Row-major twiddle-number sequencer for a 45-entry table,        |
// |            addr(r,c) = (r*c*S) mod 45 built from add/compare only.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tw45_addr_seq #(
  parameter int TW_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  rows,
  input  logic [5:0]  cols,
  input  logic [5:0]  step,
  output logic [10:0] addr,
  output logic        addr_vld,
  input  logic        addr_rdy,
  output logic        last,
  output logic        tw_vld,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam logic [6:0] c_TW_N = 7'd45;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [5:0] r_rows, r_cols, r_step;
  logic [5:0] r_row, r_col, r_acc, r_inc;
  logic       r_cfg_err;

  logic       w_run, w_fire, w_last, w_col_end, w_cfg_ok;
  logic [6:0] w_acc_sum, w_acc_wrap, w_inc_sum, w_inc_wrap;
  logic [5:0] w_acc_next, w_inc_next;

  // Only factorisations of 45 are accepted, so every run is exactly 45 fires.
  always_comb begin
    w_cfg_ok = 1'b0;
    case ({rows, cols})
      {6'd1,  6'd45},
      {6'd3,  6'd15},
      {6'd5,  6'd9},
      {6'd9,  6'd5},
      {6'd15, 6'd3},
      {6'd45, 6'd1}: w_cfg_ok = (step >= 6'd1) && (step <= 6'd44);
      default:       w_cfg_ok = 1'b0;
    endcase
  end

  assign w_run     = (r_state == S_RUN);
  assign w_fire    = w_run & addr_rdy;
  assign w_col_end = (r_col == r_cols - 6'd1);
  assign w_last    = w_run && w_col_end && (r_row == r_rows - 6'd1);

  // Both operands stay below 45, so one conditional subtract keeps the result in range.
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_acc_wrap = w_acc_sum - c_TW_N;
  assign w_acc_next = (w_acc_sum >= c_TW_N) ? w_acc_wrap[5:0] : w_acc_sum[5:0];
  assign w_inc_sum  = {1'b0, r_inc} + {1'b0, r_step};
  assign w_inc_wrap = w_inc_sum - c_TW_N;
  assign w_inc_next = (w_inc_sum >= c_TW_N) ? w_inc_wrap[5:0] : w_inc_sum[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rows    <= 6'd0;
      r_cols    <= 6'd0;
      r_step    <= 6'd0;
      r_row     <= 6'd0;
      r_col     <= 6'd0;
      r_acc     <= 6'd0;
      r_inc     <= 6'd0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_state <= S_RUN;
              r_rows  <= rows;
              r_cols  <= cols;
              r_step  <= step;
              r_row   <= 6'd0;
              r_col   <= 6'd0;
              r_acc   <= 6'd0;
              r_inc   <= 6'd0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else if (w_col_end) begin
              r_row <= r_row + 6'd1;
              r_col <= 6'd0;
              r_acc <= 6'd0;
              r_inc <= w_inc_next;
            end else begin
              r_col <= r_col + 6'd1;
              r_acc <= w_acc_next;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr     = w_run ? {5'b0, r_acc} : 11'd0;
  assign addr_vld = w_run;
  assign last     = w_last;
  assign busy     = w_run;
  assign done     = (r_state == S_DONE);
  assign cfg_err  = r_cfg_err;

  generate
    if (TW_LAT == 0) begin : g_tw_comb
      assign tw_vld = w_fire;
    end else begin : g_tw_reg
      logic r_tw_vld;
      always_ff @(posedge clk) begin
        if (rst) r_tw_vld <= 1'b0;
        else     r_tw_vld <= w_fire;
      end
      assign tw_vld = r_tw_vld;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tw45_addr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tw45_addr_seq                                                |
// | Function : Self-checking bench; one instance per table latency, expected   |
// |            twiddle numbers computed directly as (r*c*S) mod 45.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_tw45_addr_seq;

  logic        clk = 1'b0;
  logic        rst, start, addr_rdy;
  logic [5:0]  rows, cols, step;
  logic [10:0] addr, addr1;
  logic        addr_vld, last, tw_vld0, busy, done, cfg_err;
  logic        addr_vld1, last1, tw_vld1, busy1, done1, cfg_err1;

  int n_cmp = 0;
  int n_err = 0;
  int cap_q[$];

  always #5 clk = ~clk;

  tw45_addr_seq #(.TW_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols), .step(step),
    .addr(addr), .addr_vld(addr_vld), .addr_rdy(addr_rdy), .last(last),
    .tw_vld(tw_vld0), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  tw45_addr_seq #(.TW_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols), .step(step),
    .addr(addr1), .addr_vld(addr_vld1), .addr_rdy(addr_rdy), .last(last1),
    .tw_vld(tw_vld1), .busy(busy1), .done(done1), .cfg_err(cfg_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit vld, input int a, input bit lst,
                            input bit bsy, input bit dn, input bit er, input bit tw0, input bit tw1);
    chk({tag, ".addr_vld"}, 32'(addr_vld), 32'(vld));
    chk({tag, ".addr"},     32'(addr),     32'(a));
    chk({tag, ".last"},     32'(last),     32'(lst));
    chk({tag, ".busy"},     32'(busy),     32'(bsy));
    chk({tag, ".done"},     32'(done),     32'(dn));
    chk({tag, ".cfg_err"},  32'(cfg_err),  32'(er));
    chk({tag, ".tw_vld0"},  32'(tw_vld0),  32'(tw0));
    chk({tag, ".lat1_outs"},
        32'({addr_vld1, addr1, last1, busy1, done1, cfg_err1, tw_vld1}),
        32'({vld, 11'(a), lst, bsy, dn, er, tw1}));
  endtask

  // One run: expected list built from the closed-form formula, addr_rdy asserted with pct% probability.
  task automatic run(input int R, input int C, input int S, input int pct,
                     input int abort_at, input bit poke);
    int exp_q[$];
    int idx, cyc;
    bit rdy, prev_fire, prev_stall;
    logic [10:0] prev_addr;
    exp_q = {};
    cap_q = {};
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        exp_q.push_back((r * c * S) % 45);
    rows = 6'(R); cols = 6'(C); step = 6'(S); start = 1'b1; addr_rdy = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; prev_fire = 1'b0; prev_stall = 1'b0; prev_addr = '0;
    while (idx < 45 && cyc < 1000) begin
      rdy = ($urandom_range(0, 99) < pct);
      addr_rdy = rdy;
      if (poke && idx == 10) begin
        start = 1'b1; rows = 6'd45; cols = 6'd1; step = 6'd3;
      end
      #1;
      check_outs("run", 1'b1, exp_q[idx], idx == 44, 1'b1, 1'b0, 1'b0, rdy, prev_fire);
      if (prev_stall) chk("stall_hold", 32'(addr), 32'(prev_addr));
      prev_addr = addr; prev_stall = !rdy; prev_fire = rdy;
      if (rdy) begin
        cap_q.push_back(int'(addr));
        idx++;
      end
      if (rdy && idx == abort_at) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (rst) begin
        addr_rdy = 1'b1;
        #1;
        check_outs("abort", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done | done1), 32'd0);
          chk("abort_idle", 32'(busy | addr_vld | tw_vld1), 32'd0);
        end
        addr_rdy = 1'b0;
        return;
      end
    end
    chk("fire_count", 32'(idx), 32'd45);
    chk("cap_size", 32'(cap_q.size()), 32'd45);
    addr_rdy = 1'($urandom_range(0, 1));
    if (poke) begin
      start = 1'b1; rows = 6'd3; cols = 6'd15; step = 6'd9;
    end
    #1;
    check_outs("done", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check_outs("post_done", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addr_rdy = 1'b0;
  endtask

  task automatic bad_start(input int R, input int C, input int S);
    rows = 6'(R); cols = 6'(C); step = 6'(S); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check_outs("cfg_err", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    check_outs("cfg_err_end", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int row3[5];
    int row8[5];
    int pr_r[6];
    int k;
    row3 = '{0, 21, 42, 18, 39};
    row8 = '{0, 11, 22, 33, 44};
    pr_r = '{1, 3, 5, 9, 15, 45};

    rst = 1'b1; start = 1'b0; addr_rdy = 1'b0;
    rows = '0; cols = '0; step = '0;
    repeat (3) @(posedge clk);
    #1;
    addr_rdy = 1'b1;
    #1;
    check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    addr_rdy = 1'b0;
    @(posedge clk); #1;

    // Unit step, no backpressure.
    run(9, 5, 1, 100, -1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("s1_row1", 32'(cap_q[5 + c]), 32'(c));
      chk("s1_row8", 32'(cap_q[40 + c]), 32'(8 * c));
    end

    // S=7 exercises the modulo wrap.
    run(9, 5, 7, 100, -1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("s7_row3", 32'(cap_q[15 + c]), 32'(row3[c]));
      chk("s7_row8", 32'(cap_q[40 + c]), 32'(row8[c]));
    end

    run(5, 9, 1, 50, -1, 1'b0);

    bad_start(4, 11, 1);
    bad_start(9, 5, 0);
    bad_start(9, 5, 45);

    run(9, 5, 3, 100, 20, 1'b0);
    run(15, 3, 2, 70, -1, 1'b0);

    // Start pulses during RUN and DONE must be ignored.
    run(45, 1, 5, 60, -1, 1'b1);
    run(1, 45, 44, 100, -1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      k = int'($urandom_range(0, 5));
      run(pr_r[k], 45 / pr_r[k], int'($urandom_range(1, 44)),
          int'($urandom_range(30, 100)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tw45_addr_seq.md
TW45_ADDR_SEQ -- requirements
Module: tw45_addr_seq

Interface
REQ-001 SHALL have parameter TW_LAT, default 0, meaning twiddle-table read latency in cycles (0 = combinational table, 1 = registered table output); only 0 and 1 are legal.
REQ-002 SHALL have port clk  input  1  master clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  single-cycle run request, sampled only in IDLE.
REQ-005 SHALL have port rows  input  6  outer-loop length R, latched on accepted start.
REQ-006 SHALL have port cols  input  6  inner-loop length C, latched on accepted start.
REQ-007 SHALL have port step  input  6  twiddle exponent multiplier S, latched on accepted start.
REQ-008 SHALL have port addr  output  11  twiddle number presented to the 45-entry twiddle table.
REQ-009 SHALL have port addr_vld  output  1  addr holds a valid twiddle number.
REQ-010 SHALL have port addr_rdy  input  1  consumer accepts addr; fire = addr_vld & addr_rdy.
REQ-011 SHALL have port last  output  1  current addr is the final element of the run.
REQ-012 SHALL have port tw_vld  output  1  twiddle table output corresponds to a fired addr.
REQ-013 SHALL have port busy  output  1  high in RUN.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: start with legal config -> RUN next cycle, latch R, C, S; row = 0, col = 0, acc = 0, inc = 0.
REQ-018 Legal config: (R,C) in {(1,45),(3,15),(5,9),(9,5),(15,3),(45,1)} and 1 <= S <= 44.
REQ-019 Start with illegal config: cfg_err = 1 for the next cycle; state stays IDLE; no addr_vld.
REQ-020 Start while in RUN or DONE: ignored; latched config unchanged.
REQ-021 RUN: addr_vld = 1, addr = {5'b0, acc}; sequence is row-major, row outer, col inner; addr(r,c) = (r*c*S) mod 45.
REQ-022 On fire with col < C-1: col += 1; acc = acc + inc, minus 45 if the sum >= 45.
REQ-023 On fire with col = C-1 and row < R-1: row += 1; col = 0; acc = 0; inc = inc + S, minus 45 if the sum >= 45.
REQ-024 acc and inc SHALL always stay in 0..44; a single conditional subtract is sufficient and is the only modulo used (no multiplier, no divider).
REQ-025 No fire (addr_rdy = 0): addr, last, row, col, acc, inc SHALL hold.
REQ-026 last = 1 exactly while row = R-1 and col = C-1 in RUN.
REQ-027 Fire with last = 1 -> DONE; addr_vld = 0 next cycle.
REQ-028 DONE: done = 1 for exactly one cycle, then -> IDLE; a start during DONE is ignored.
REQ-029 Exactly 45 fires per run regardless of addr_rdy pattern.
REQ-030 TW_LAT = 0: tw_vld = fire (same cycle).
REQ-031 TW_LAT = 1: tw_vld = fire registered by one cycle, even if the following cycle stalls.
REQ-032 addr SHALL be 0 whenever addr_vld = 0.

Reset
REQ-033 rst = 1 at a clock edge -> IDLE; row, col, acc, inc, and latched R, C, S cleared to 0.
REQ-034 Outputs after reset: addr = 0; addr_vld, last, tw_vld, busy, done, cfg_err = 0.
REQ-035 rst mid-RUN aborts the run; no done pulse; any pending tw_vld is cleared.
REQ-036 rst has priority over start in the same cycle.

Verification
REQ-037 R=9, C=5, S=1, addr_rdy = 1: 45 consecutive fires. Row 1 gives 0,1,2,3,4; row 8 gives 0,8,16,24,32. last on fire 45; done one cycle later.
REQ-038 R=9, C=5, S=7: row 3 gives 0,21,42,18,39; row 8 gives 0,11,22,33,44 (checks wrap).
REQ-039 R=5, C=9, S=1, addr_rdy random at 50%: addr and last stable during stalls; fired sequence identical to R=5, C=9, S=1 with no stall; count = 45.
REQ-040 Start with R=4, C=11, then with R=9, C=5, S=0: cfg_err pulse each time; busy stays 0; no addr_vld.
REQ-041 TW_LAT=1: tw_vld equals fire delayed 1 cycle; rst asserted at fire 20 gives all outputs 0 next cycle and no done.
REQ-042 Start pulsed during RUN and during DONE: ignored; config unchanged; next legal start in IDLE runs normally.
